// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the MIPS pipeline. Owns the program counter,
// drives the byte address into the word-indexed instruction memory, and
// captures the returned instruction into the IF/ID pipeline register.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   imem_addr     byte address to instruction memory (equals pc)
//   imem_instr    instruction word returned combinationally by memory
//   stall         hold PC and IF/ID (hazard unit)
//   redirect      taken branch/jump this cycle
//   redirect_pc   target byte address for redirect
//   if_id_instr   registered instruction
//   if_id_pc4     registered address of that instruction + 4
//   if_id_valid   IF/ID holds a real instruction (0 = bubble)
//   pc            current fetch PC
//   misalign_err  sticky: a redirect target was not word aligned
//   oob_err       sticky: PC reached an out-of-range address
//   fetch_count   saturating count of instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'd40,
  parameter int          MEM_WORDS = 250
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] pc,
  output logic        misalign_err,
  output logic        oob_err,
  output logic [31:0] fetch_count
);

  // First byte address that lies beyond the instruction memory.
  localparam logic [31:0] MemLimit = 32'(4 * MEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifIdInstr_q, ifIdInstr_d;
  logic [31:0] ifIdPc4_q, ifIdPc4_d;
  logic        ifIdValid_q, ifIdValid_d;
  logic        misalignErr_q, misalignErr_d;
  logic        oobErr_q, oobErr_d;
  logic [31:0] fetchCount_q, fetchCount_d;
  logic [31:0] pcPlus4;

  // Wraps modulo 2^32 naturally.
  assign pcPlus4 = pc_q + 32'd4;

  // Next-state selection. Redirect beats stall so a taken branch is never
  // lost behind a hazard; an out-of-range PC parks and feeds bubbles until
  // something redirects it.
  always_comb begin
    pc_d          = pc_q;
    ifIdInstr_d   = ifIdInstr_q;
    ifIdPc4_d     = ifIdPc4_q;
    ifIdValid_d   = ifIdValid_q;
    misalignErr_d = misalignErr_q;
    oobErr_d      = oobErr_q;
    fetchCount_d  = fetchCount_q;

    if (redirect) begin
      pc_d        = {redirect_pc[31:2], 2'b00};
      ifIdInstr_d = 32'd0;
      ifIdPc4_d   = 32'd0;
      ifIdValid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalignErr_d = 1'b1;
      end
    end else if (stall) begin
      // everything holds
    end else if (pc_q >= MemLimit) begin
      ifIdInstr_d = 32'd0;
      ifIdPc4_d   = 32'd0;
      ifIdValid_d = 1'b0;
      oobErr_d    = 1'b1;
    end else begin
      pc_d        = pcPlus4;
      ifIdInstr_d = imem_instr;
      ifIdPc4_d   = pcPlus4;
      ifIdValid_d = 1'b1;
      if (fetchCount_q != 32'hFFFF_FFFF) begin
        fetchCount_d = fetchCount_q + 32'd1;
      end
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifIdInstr_q   <= 32'd0;
      ifIdPc4_q     <= 32'd0;
      ifIdValid_q   <= 1'b0;
      misalignErr_q <= 1'b0;
      oobErr_q      <= 1'b0;
      fetchCount_q  <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      ifIdInstr_q   <= ifIdInstr_d;
      ifIdPc4_q     <= ifIdPc4_d;
      ifIdValid_q   <= ifIdValid_d;
      misalignErr_q <= misalignErr_d;
      oobErr_q      <= oobErr_d;
      fetchCount_q  <= fetchCount_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign if_id_instr  = ifIdInstr_q;
  assign if_id_pc4    = ifIdPc4_q;
  assign if_id_valid  = ifIdValid_q;
  assign misalign_err = misalignErr_q;
  assign oob_err      = oobErr_q;
  assign fetch_count  = fetchCount_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline. Sits directly upstream of the instruction memory and feeds it.
- Owns the program counter and drives the byte address into the word-indexed instruction memory.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall, redirect (branch/jump) flush, address-range checking and a fetch counter.

Parameters:
- RESET_PC, 32'd40, byte address loaded into PC on reset; first program word lives at word 10.
- MEM_WORDS, 250, number of 32-bit words in the instruction memory; byte addresses at or above 4*MEM_WORDS are out of range.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_addr  output  32  byte address to instruction memory; combinationally equal to pc
- imem_instr  input  32  instruction word returned combinationally by memory for imem_addr
- stall  input  1  hold PC and IF/ID register (hazard unit)
- redirect  input  1  taken branch/jump this cycle
- redirect_pc  input  32  target byte address for redirect
- if_id_instr  output  32  registered instruction
- if_id_pc4  output  32  registered address of that instruction + 4
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- pc  output  32  current fetch PC
- misalign_err  output  1  sticky: a redirect target had nonzero bits [1:0]
- oob_err  output  1  sticky: PC reached out-of-range address
- fetch_count  output  32  saturating count of instructions loaded into IF/ID

Behaviour:
- All state is updated on the rising clk edge. The memory read is combinational, so fetch latency is 1 cycle: the word at pc appears in IF/ID on the next edge.
- Reset (synchronous, active-high; wins over every other input):
  - pc = RESET_PC
  - if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0
  - misalign_err = 0, oob_err = 0, fetch_count = 0
- Per-cycle priority when reset = 0: redirect > stall > out-of-range > normal.
- Redirect:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID flushed: if_id_valid <= 0, if_id_instr <= 0, if_id_pc4 <= 0.
  - If redirect_pc[1:0] != 0, set misalign_err.
  - Applies even when stall = 1.
  - fetch_count unchanged.
- Stall (no redirect): pc, IF/ID and fetch_count all hold their values.
- Out-of-range (no redirect, no stall, pc >= 4*MEM_WORDS):
  - pc holds.
  - IF/ID loads a bubble (valid 0, instr 0, pc4 0).
  - Set oob_err. fetch_count unchanged.
  - Only a redirect or reset moves pc out of this condition.
- Normal:
  - if_id_instr <= imem_instr, if_id_pc4 <= pc + 4, if_id_valid <= 1.
  - pc <= pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - fetch_count <= fetch_count + 1, saturating at 0xFFFFFFFF.
- Sticky flags clear only on reset.
- An all-zero instruction (sll $0,$0,0) is a legal NOP: it is captured with valid = 1 and counted.
- Redirect to an out-of-range target: pc takes the target. Out-of-range handling applies from the next cycle.
- Reset asserted mid-stall or mid-redirect: reset values take effect on that edge. No pending redirect survives reset.

Test Plan:
- Reset then 3 free-running cycles:
  - Memory words 10..12 = 0x20080002, 0xAC850000, 0x8C860000.
  - imem_addr sequence 40, 44, 48.
  - if_id_instr sequence 0x20080002 (pc4 44), 0xAC850000 (pc4 48), 0x8C860000 (pc4 52), each with valid = 1.
  - fetch_count = 3.
- Stall held 2 cycles after the first fetch: pc stays 44 and if_id_instr stays 0x20080002 for both cycles. On release, the next capture is 0xAC850000.
- Redirect and stall together with redirect_pc = 40 while pc = 48:
  - Next edge: pc = 40, if_id_valid = 0, fetch_count unchanged.
  - Following edge: if_id_instr = 0x20080002.
- Redirect with redirect_pc = 0x0000002E: pc = 0x2C, misalign_err = 1 and remains 1 after further redirects. Reset clears it.
- Redirect to 996 (word 249), then free-run:
  - Word 249 captured with valid = 1; pc becomes 1000.
  - Next cycle: bubble, oob_err = 1, pc held at 1000 for 5 cycles.
  - Redirect to 40 resumes normal fetch.
- Reset asserted during stall with pc = 48: next edge pc = 40, all IF/ID outputs 0, fetch_count = 0.
